// File: rtl/hls_seq_pkg.sv
// Shared constants and types for the HLS core sequencer.
// Word sizing matches the ap_fixed<16,6> core interface.
package hls_seq_pkg;

    localparam int WIDTH = 16;
    localparam int NFRAC = 10;
    localparam int N_IN  = 16;
    localparam int N_OUT = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LAUNCH = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_PUSH   = 2'd3;

    typedef logic [N_OUT*WIDTH-1:0] result_t;

    function automatic logic [WIDTH-1:0] lane_of(
        input result_t r,
        input int      k
    );
        return r[k*WIDTH +: WIDTH];
    endfunction

endpackage

// File: rtl/hls_seq_result_fifo.sv
// Two-entry result FIFO between the sequencer and the consumer.
// The full flag is a register, so a pop does not free a slot that cycle.
module hls_seq_result_fifo #(
    parameter int DW = 80
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    output logic          o_full,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);

    logic [DW-1:0] r_mem0;
    logic [DW-1:0] r_mem1;
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_cnt;
    logic          r_full;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_cnt_next;

    assign w_push  = i_push && !r_full;
    assign w_pop   = o_valid && i_ready;
    assign o_valid = (r_cnt != 2'd0);
    assign o_full  = r_full;
    assign o_data  = r_rptr ? r_mem1 : r_mem0;

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_next = r_cnt + 2'd1;
        end else if (!w_push && w_pop) begin
            w_cnt_next = r_cnt - 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
            r_full <= 1'b0;
        end else begin
            if (w_push) begin
                if (r_wptr) begin
                    r_mem1 <= i_data;
                end else begin
                    r_mem0 <= i_data;
                end
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt  <= w_cnt_next;
            r_full <= (w_cnt_next == 2'd2);
        end
    end

endmodule

// File: rtl/hls_core_sequencer.sv
// Drives one HLS inference core: launch, collect lanes, time out, buffer.
// Lane data passes through untouched; only control is generated here.
module hls_core_sequencer #(
    parameter int WIDTH       = hls_seq_pkg::WIDTH,
    parameter int N_IN        = hls_seq_pkg::N_IN,
    parameter int N_OUT       = hls_seq_pkg::N_OUT,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [N_IN*WIDTH-1:0]  s_data,
    output logic                   core_start,
    output logic                   core_in_vld,
    output logic [N_IN*WIDTH-1:0]  core_in,
    input  logic                   core_done,
    input  logic                   core_idle,
    input  logic                   core_ready,
    input  logic [N_OUT*WIDTH-1:0] core_out,
    input  logic [N_OUT-1:0]       core_out_vld,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [N_OUT*WIDTH-1:0] m_data,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [31:0]            result_cnt
);

    import hls_seq_pkg::*;

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    state_t                 r_state;
    logic [N_IN*WIDTH-1:0]  r_core_in;
    logic [N_OUT*WIDTH-1:0] r_res;
    logic [N_OUT-1:0]       r_got;
    logic                   r_done_seen;
    logic [TW-1:0]          r_tmo;
    logic                   r_tmo_err;
    logic [31:0]            r_cnt;

    logic [N_OUT*WIDTH-1:0] w_res_next;
    logic [N_OUT-1:0]       w_got_next;
    logic                   w_done_next;
    logic                   w_complete;
    logic                   w_tmo_hit;
    logic                   w_fifo_full;
    logic                   w_fifo_push;
    logic                   w_accept;
    logic                   w_unused;

    // The core's ap_ready carries no information the sequencer needs.
    assign w_unused = core_ready;

    assign s_ready     = (r_state == ST_IDLE) && core_idle;
    assign w_accept    = s_valid && s_ready;
    assign core_start  = (r_state == ST_LAUNCH);
    assign core_in_vld = (r_state == ST_LAUNCH);
    assign core_in     = r_core_in;
    assign busy        = (r_state != ST_IDLE);
    assign timeout_err = r_tmo_err;
    assign result_cnt  = r_cnt;

    always_comb begin
        w_res_next = r_res;
        for (int k = 0; k < N_OUT; k++) begin
            if (core_out_vld[k]) begin
                w_res_next[k*WIDTH +: WIDTH] = core_out[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_got_next  = r_got | core_out_vld;
    assign w_done_next = r_done_seen | core_done;
    assign w_complete  = (&w_got_next) && w_done_next;
    assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT_CYC - 1));
    assign w_fifo_push = (r_state == ST_PUSH) && !w_fifo_full;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= ST_IDLE;
            r_core_in   <= '0;
            r_res       <= '0;
            r_got       <= '0;
            r_done_seen <= 1'b0;
            r_tmo       <= '0;
            r_tmo_err   <= 1'b0;
            r_cnt       <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_core_in   <= s_data;
                        r_res       <= '0;
                        r_got       <= '0;
                        r_done_seen <= 1'b0;
                        r_state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_tmo   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_res       <= w_res_next;
                    r_got       <= w_got_next;
                    r_done_seen <= w_done_next;
                    // Completion outranks a timeout landing in the same cycle.
                    if (w_complete) begin
                        r_state <= ST_PUSH;
                    end else if (w_tmo_hit) begin
                        r_tmo_err <= 1'b1;
                        r_got     <= '0;
                        r_res     <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                ST_PUSH: begin
                    if (!w_fifo_full) begin
                        r_cnt   <= r_cnt + 32'd1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    hls_seq_result_fifo #(
        .DW(N_OUT*WIDTH)
    ) u_fifo (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_push  (w_fifo_push),
        .i_data  (r_res),
        .o_full  (w_fifo_full),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_data  (m_data)
    );

endmodule
